// File: rtl/message_streamer_pkg.sv
// Shared types and constants for the message streamer and its key generator.
package msg_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EMIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int          DEF_DATA_W   = 9;
  localparam int          DEF_ADDR_W   = 9;
  localparam int          DEF_NUM_MSG  = 4;
  localparam int          DEF_SLOT_LEN = 128;
  localparam logic [31:0] DEF_SEED     = 32'h0000_01A5;

  // Feedback mask for a maximal-length Fibonacci LFSR of width w
  // (bit i set means stage i+1 of the shift register feeds the XOR).
  function automatic logic [31:0] lfsr_taps(input int w);
    case (w)
      3:       return 32'h0000_0006;
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0829;
      13:      return 32'h0000_100D;
      14:      return 32'h0000_2015;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_D008;
      default: return 32'h0000_0110;
    endcase
  endfunction

endpackage

// File: rtl/message_streamer_if.sv
// ROM pointer/data pair and the outgoing valid/ready character stream.
interface message_streamer_if #(
  parameter int DATA_W = 9,
  parameter int ADDR_W = 9
);
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output rom_addr, out_data, out_valid,
    input  rom_data, out_ready
  );

  modport slave (
    input  rom_addr, out_data, out_valid,
    output rom_data, out_ready
  );
endinterface

// File: rtl/message_streamer_lfsr.sv
// Descrambling key generator: a maximal Fibonacci LFSR that is loaded with a
// seed at message start and advances once per accepted character.
module msg_lfsr
  import msg_stream_pkg::*;
#(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         step_i,
  input  logic [W-1:0] seed_i,
  output logic [W-1:0] key_o
);
  localparam logic [31:0]  TAPS32 = lfsr_taps(W);
  localparam logic [W-1:0] TAPS   = TAPS32[W-1:0];

  logic [W-1:0] lfsr_q;

  // Load on start, otherwise shift in the tap parity on each step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= '1;
    end else if (load_i) begin
      lfsr_q <= seed_i;
    end else if (step_i) begin
      lfsr_q <= {lfsr_q[W-2:0], ^(lfsr_q & TAPS)};
    end
  end

  assign key_o = lfsr_q;
endmodule

// File: rtl/message_streamer.sv
// Streams one message slot from an external combinational ROM out a
// valid/ready character interface, stopping at the terminator word or at the
// end of the slot. Optional descrambling is enabled by MSG_DESCRAMBLE_EN.
module message_streamer
  import msg_stream_pkg::*;
#(
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                NUM_MSG  = DEF_NUM_MSG,
  parameter int                SLOT_LEN = DEF_SLOT_LEN,
  parameter logic [DATA_W-1:0] TERM     = '1,
  parameter logic [DATA_W-1:0] SEED     = DEF_SEED[DATA_W-1:0]
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        start,
  input  logic [$clog2(NUM_MSG > 1 ? NUM_MSG : 2)-1:0] msg_sel,
  input  logic                                        abort,
  output logic                                        busy,
  output logic                                        done,
  output logic                                        overrun,
  message_streamer_if.master                          bus
);
  localparam int MSG_W = $clog2(NUM_MSG > 1 ? NUM_MSG : 2);
  localparam int OFF_W = $clog2(SLOT_LEN);
  localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(SLOT_LEN - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q;
  logic [OFF_W-1:0]  offset_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q;
  logic              overrun_q;

  logic              is_term;
  logic              handshake;
  logic              at_last;
  logic              accept_start;
  logic [ADDR_W-1:0] slot_base;
  logic [DATA_W-1:0] char_w;

  assign is_term      = (bus.rom_data == TERM);
  assign handshake    = out_valid_q & bus.out_ready;
  assign at_last      = (offset_q == OFF_LAST);
  assign accept_start = (state_q == IDLE) & start;

  // Slot base address; an out-of-range selector falls back to slot 0.
  always_comb begin
    slot_base = '0;
    if (32'(msg_sel) < NUM_MSG) begin
      slot_base = ADDR_W'(32'(msg_sel) * SLOT_LEN);
    end
  end

`ifdef MSG_DESCRAMBLE_EN
  logic [DATA_W-1:0] key;

  msg_lfsr #(.W(DATA_W)) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (accept_start),
    .step_i ((state_q == EMIT) & handshake & ~abort),
    .seed_i (SEED),
    .key_o  (key)
  );

  assign char_w = bus.rom_data ^ key;
`else
  assign char_w = bus.rom_data;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort wins over any handshake or terminator.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = FETCH;
      FETCH: begin
        if (abort)        state_d = IDLE;
        else if (is_term) state_d = DONE;
        else              state_d = EMIT;
      end
      EMIT: begin
        if (abort)          state_d = IDLE;
        else if (handshake) state_d = at_last ? DONE : FETCH;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pointer, offset, output character and overrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr_q  <= '0;
      offset_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            rom_addr_q <= slot_base;
            offset_q   <= '0;
            overrun_q  <= 1'b0;
          end
        end
        FETCH: begin
          if (!abort && !is_term) begin
            out_data_q  <= char_w;
            out_valid_q <= 1'b1;
          end
        end
        EMIT: begin
          if (abort) begin
            out_valid_q <= 1'b0;
          end else if (handshake) begin
            out_valid_q <= 1'b0;
            if (at_last) begin
              overrun_q <= 1'b1;
            end else begin
              offset_q   <= offset_q + 1'b1;
              rom_addr_q <= rom_addr_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Status outputs decoded from the current state.
  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  assign overrun       = overrun_q;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_message_streamer.sv
// Directed and randomized bench for message_streamer with a queue-based
// reference model of the slot contents.
module tb_message_streamer;
  localparam int DATA_W   = 9;
  localparam int ADDR_W   = 9;
  localparam int NUM_MSG  = 4;
  localparam int SLOT_LEN = 128;
  localparam logic [8:0] TERM = 9'h1FF;
  localparam logic [8:0] SEED = 9'h1A5;
`ifdef MSG_DESCRAMBLE_EN
  localparam bit DESC = 1'b1;
`else
  localparam bit DESC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, start, abort;
  logic [1:0] msg_sel;
  logic       busy, done, overrun;
  logic [8:0] rom [0:511];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  message_streamer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
  assign bus.rom_data = rom[bus.rom_addr];

  message_streamer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_MSG(NUM_MSG), .SLOT_LEN(SLOT_LEN),
    .TERM(TERM), .SEED(SEED)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .msg_sel(msg_sel), .abort(abort),
    .busy(busy), .done(done), .overrun(overrun), .bus(bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Key sequence of the polynomial x^9 + x^5 + 1, shifting toward the MSB.
  function automatic logic [8:0] key_next(input logic [8:0] k);
    return {k[7:0], k[8] ^ k[4]};
  endfunction

  // Start a message, drive out_ready according to mode (0: always high,
  // 1: random, 2: low for the first 5 valid cycles), and compare everything
  // accepted against the model of the slot.
  task automatic run_msg(input int slot, input int mode, input bit inject);
    logic [8:0] expq[$];
    logic [8:0] gotq[$];
    logic [8:0] key, w;
    bit exp_over, prev_stall, r;
    logic [8:0] prev_data, prev_addr;
    int base, done_cycle, done_cnt, first_valid, addr_bad, stall_cnt;
    base = slot * SLOT_LEN;
    key = SEED; exp_over = 0;
    for (int i = 0; i < SLOT_LEN; i++) begin
      w = rom[base + i];
      if (w == TERM) break;
      expq.push_back(DESC ? (w ^ key) : w);
      key = key_next(key);
      if (i == SLOT_LEN - 1) exp_over = 1;
    end
    done_cycle = -1; done_cnt = 0; first_valid = -1; addr_bad = 0; stall_cnt = 0;
    prev_stall = 0; prev_data = '0; prev_addr = '0;
    @(negedge clk);
    start = 1'b1; msg_sel = slot[1:0]; bus.out_ready = (mode == 0);
    for (int c = 1; c < 2000; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 1) begin
        check("overrun_cleared", 32'(overrun), 0);
        check("busy_after_start", 32'(busy), 1);
        check("rom_addr_base", 32'(bus.rom_addr), base);
      end
      if (prev_stall) begin
        check("stall_valid", 32'(bus.out_valid), 1);
        check("stall_data", 32'(bus.out_data), 32'(prev_data));
        check("stall_addr", 32'(bus.rom_addr), 32'(prev_addr));
      end
      if (done) begin
        done_cnt++;
        if (done_cycle < 0) done_cycle = c;
      end
      if (bus.out_valid && first_valid < 0) first_valid = c;
      if (busy && (int'(bus.rom_addr) < base || int'(bus.rom_addr) > base + SLOT_LEN - 1))
        addr_bad++;
      case (mode)
        0:       r = 1'b1;
        1:       r = 1'($urandom_range(0, 1));
        default: r = (stall_cnt >= 5);
      endcase
      if (bus.out_valid && !r) stall_cnt++;
      bus.out_ready = r;
      if (bus.out_valid && r) gotq.push_back(bus.out_data);
      prev_stall = bus.out_valid && !r;
      prev_data  = bus.out_data;
      prev_addr  = bus.rom_addr;
      if (inject && c == 3 && busy) begin
        start = 1'b1;
        msg_sel = 2'(slot ^ 1);
      end
      if (done_cycle >= 0 && c >= done_cycle + 2) break;
    end
    bus.out_ready = 1'b0;
    check("done_seen", 32'(done_cycle >= 0), 1);
    check("done_count", done_cnt, 1);
    check("busy_after_done", 32'(busy), 0);
    check("overrun_flag", 32'(overrun), 32'(exp_over));
    check("addr_in_slot", addr_bad, 0);
    check("char_count", gotq.size(), expq.size());
    for (int i = 0; i < expq.size() && i < gotq.size(); i++)
      check($sformatf("char[%0d]", i), 32'(gotq[i]), 32'(expq[i]));
    if (mode == 0) begin
      check("first_valid_cycle", first_valid, expq.size() == 0 ? -1 : 2);
      check("done_cycle", done_cycle,
            exp_over ? 2 * expq.size() + 1 : 2 * expq.size() + 2);
    end
    $display("msg slot=%0d mode=%0d inject=%0d: %0d chars, done at cycle %0d, overrun=%0b",
             slot, mode, inject, gotq.size(), done_cycle, overrun);
  endtask

  initial begin
    logic [8:0] k0, k1;
    int len;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; msg_sel = '0; bus.out_ready = 1'b0;
    for (int i = 0; i < 512; i++) rom[i] = TERM;
    rom[0] = 9'h048; rom[1] = 9'h069;                 // "Hi", TERM
    for (int i = 256; i < 384; i++) rom[i] = 9'h041;  // slot 2: no terminator
    k0 = SEED; k1 = key_next(k0);
    rom[384] = 9'h04F ^ k0; rom[385] = 9'h04B ^ k1;   // scrambled "OK"

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rom_addr", 32'(bus.rom_addr), 0);
    check("rst_out_data", 32'(bus.out_data), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_overrun", 32'(overrun), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_msg(0, 0, 0);   // "Hi": timing and content
    run_msg(1, 0, 0);   // empty message
    run_msg(2, 1, 1);   // full slot, no terminator, random backpressure
    run_msg(0, 2, 0);   // 5-cycle stall on the first character
    run_msg(3, 0, 1);   // scrambled "OK", start while busy ignored
    if (DESC) begin
      check("ok_first_key", 32'(rom[384] ^ k0), 32'h04F);
    end

    // Abort during the third character
    rom[2] = 9'h021; rom[3] = TERM;
    @(negedge clk);
    start = 1'b1; msg_sel = 2'd0; bus.out_ready = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("abort_pre_valid", 32'(bus.out_valid), 1);
    check("abort_pre_data", 32'(bus.out_data), DESC ? 32'(9'h021 ^ key_next(key_next(SEED))) : 32'h021);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_valid_drop", 32'(bus.out_valid), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_no_done", 32'(done), 0);
    @(negedge clk);
    check("abort_no_done_late", 32'(done), 0);
    bus.out_ready = 1'b0;
    $display("abort: message cut after 2 chars");
    run_msg(0, 0, 0);   // replays from 'H'

    // Asynchronous reset in the middle of a message
    @(negedge clk);
    start = 1'b1; msg_sel = 2'd2; bus.out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_rom_addr", 32'(bus.rom_addr), 0);
    check("arst_out_data", 32'(bus.out_data), 0);
    check("arst_done", 32'(done), 0);
    @(negedge clk);
    check("arst_done_late", 32'(done), 0);
    rst_n = 1'b1; bus.out_ready = 1'b0;
    $display("async reset: outputs returned to reset values");

    // Randomized slot contents
    for (int t = 0; t < 6; t++) begin
      len = (t == 5) ? SLOT_LEN : $urandom_range(0, 40);
      for (int i = 0; i < SLOT_LEN; i++)
        rom[384 + i] = (i < len) ? 9'($urandom_range(0, 510)) : TERM;
      run_msg(3, 1, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
